board_frame_reader: RTL and testbench

- Display-side consumer of the object memory (OM) and counterpart of the game logic's `new_state`/`next_screen` handshake.
- Snapshots the 10x10 board and the header words into a shadow copy during vertical blanking. The snapshot is taken only when the game logic has flagged a consistent state.
- Pulses `next_screen` once per frame, after which the game logic may modify OM.
- Streams per-pixel tile information from the shadow copy to the VGA colouriser.

---
 rtl/board_frame_reader.sv | 145 ++++++++++++++
 tb/tb_board_frame_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_frame_reader.sv
// Display-side reader of the object memory. During vertical blanking it copies
// the board and header words into a shadow copy, then hands OM back to the game
// logic with a one-cycle next_screen pulse. Pixels are served from the shadow.
module board_frame_reader #(
    parameter int unsigned GRID      = 10,
    parameter int unsigned TILE_SIZE = 48,
    parameter int unsigned BOARD_X0  = 80,
    parameter int unsigned BOARD_Y0  = 0,
    parameter int unsigned HDR_BASE  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_state,
    output logic        next_screen,
    output logic [6:0]  address_read_om,
    input  logic [10:0] data_read_om,
    input  logic        frame_start,
    input  logic [9:0]  px_x,
    input  logic [9:0]  px_y,
    input  logic        px_active,
    output logic [10:0] tile_word,
    output logic [5:0]  tile_px,
    output logic [5:0]  tile_py,
    output logic        in_board,
    output logic [6:0]  star_count,
    output logic [13:0] cowboy_pos
);

    localparam int unsigned CELLS     = GRID * GRID;
    localparam int unsigned LAST_ADDR = HDR_BASE + 2;
    localparam int unsigned BOARD_PX  = GRID * TILE_SIZE;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COPY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        pending_q;
    logic        start_copy;
    logic        cap_en;
    logic [6:0]  cap_idx;
    logic [10:0] shadow_q [CELLS];

    logic [10:0] dx, dy;
    logic        on_board;
    logic [6:0]  cell_idx;
    logic [5:0]  off_x, off_y;

    // DONE lasts exactly one cycle, so the pulse is a state decode.
    assign next_screen = (state_q == DONE);

    // Next-state decode; frame_start is only honoured in IDLE.
    always_comb begin
        state_d    = state_q;
        start_copy = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (pending_q) begin
                        state_d    = COPY;
                        start_copy = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            COPY:    if (address_read_om == 7'(LAST_ADDR)) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // OM data lags the address by one cycle; in DRAIN the address is held at
    // the last header word, so no offset is applied there.
    always_comb begin
        cap_en  = ((state_q == COPY) && (address_read_om != 7'd0)) || (state_q == DRAIN);
        cap_idx = (state_q == DRAIN) ? address_read_om : address_read_om - 7'd1;
    end

    // Copy control, address sequencing and shadow capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pending_q       <= 1'b0;
            address_read_om <= 7'd0;
            star_count      <= 7'd0;
            cowboy_pos      <= 14'd0;
            for (int i = 0; i < CELLS; i++) shadow_q[i] <= 11'd0;
        end else begin
            state_q <= state_d;
            // A new_state coinciding with a copy start stays pending for next frame.
            pending_q <= new_state | (pending_q & ~start_copy);
            if (state_q == COPY && address_read_om != 7'(LAST_ADDR)) begin
                address_read_om <= address_read_om + 7'd1;
            end else if (state_q == DRAIN || start_copy) begin
                address_read_om <= 7'd0;
            end
            if (cap_en) begin
                if (cap_idx < 7'(CELLS)) begin
                    shadow_q[cap_idx] <= data_read_om;
                end else if (cap_idx == 7'(HDR_BASE)) begin
                    cowboy_pos[13:7] <= data_read_om[6:0];
                end else if (cap_idx == 7'(HDR_BASE + 1)) begin
                    cowboy_pos[6:0] <= data_read_om[6:0];
                end else if (cap_idx == 7'(LAST_ADDR)) begin
                    star_count <= data_read_om[6:0];
                end
            end
        end
    end

    // Board hit test and cell/offset split; negative offsets wrap high and fail the range test.
    always_comb begin
        dx       = {1'b0, px_x} - 11'(BOARD_X0);
        dy       = {1'b0, px_y} - 11'(BOARD_Y0);
        on_board = px_active && (dx < 11'(BOARD_PX)) && (dy < 11'(BOARD_PX));
        cell_idx = 7'((32'(dy) / TILE_SIZE) * GRID + 32'(dx) / TILE_SIZE);
        off_x    = 6'(32'(dx) % TILE_SIZE);
        off_y    = 6'(32'(dy) % TILE_SIZE);
    end

    // Registered pixel outputs, forced to zero off the board.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_board  <= 1'b0;
            tile_word <= 11'd0;
            tile_px   <= 6'd0;
            tile_py   <= 6'd0;
        end else begin
            in_board <= on_board;
            if (on_board) begin
                tile_word <= shadow_q[cell_idx];
                tile_px   <= off_x;
                tile_py   <= off_y;
            end else begin
                tile_word <= 11'd0;
                tile_px   <= 6'd0;
                tile_py   <= 6'd0;
            end
        end
    end

endmodule

// File: tb/tb_board_frame_reader.sv
// Bench for board_frame_reader: a synchronous OM model feeds the DUT, next_screen
// pulses and pixel results are scored against queued expectations.
module tb_board_frame_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_state;
    logic        next_screen;
    logic [6:0]  address_read_om;
    logic [10:0] data_read_om;
    logic        frame_start;
    logic [9:0]  px_x, px_y;
    logic        px_active;
    logic [10:0] tile_word;
    logic [5:0]  tile_px, tile_py;
    logic        in_board;
    logic [6:0]  star_count;
    logic [13:0] cowboy_pos;

    board_frame_reader dut (
        .clk            (clk),
        .rst            (rst),
        .new_state      (new_state),
        .next_screen    (next_screen),
        .address_read_om(address_read_om),
        .data_read_om   (data_read_om),
        .frame_start    (frame_start),
        .px_x           (px_x),
        .px_y           (px_y),
        .px_active      (px_active),
        .tile_word      (tile_word),
        .tile_px        (tile_px),
        .tile_py        (tile_py),
        .in_board       (in_board),
        .star_count     (star_count),
        .cowboy_pos     (cowboy_pos)
    );

    always #5 clk = ~clk;

    logic [10:0] mem [0:127];
    logic [10:0] shadow_m [0:99];
    always @(posedge clk) data_read_om <= mem[address_read_om];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;
    int ns_exp[$];
    logic [23:0] px_q[$];
    logic addr_moved;

    // next_screen scoreboard: every pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (address_read_om != 7'd0) addr_moved = 1'b1;
        if (!rst && next_screen) begin
            vectors++;
            if (ns_exp.size() == 0) begin
                errors++;
                $display("FAIL next_screen_extra: pulse at cycle %0d, required none", cyc);
            end else begin
                int e;
                e = ns_exp.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL next_screen_cycle: got cycle %0d, required %0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic logic [23:0] px_model(int x, int y, logic act);
        int col, row;
        if (act && x >= 80 && x < 560 && y >= 0 && y < 480) begin
            col = (x - 80) / 48;
            row = y / 48;
            return {1'b1, shadow_m[row * 10 + col], 6'(x - 80 - col * 48), 6'(y - row * 48)};
        end
        return 24'd0;
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_new_state();
        new_state = 1'b1;
        step(1);
        new_state = 1'b0;
    endtask

    task automatic pulse_frame(logic copy);
        frame_start = 1'b1;
        ns_exp.push_back(cyc + (copy ? 105 : 1));
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic snap_model();
        for (int i = 0; i < 100; i++) shadow_m[i] = mem[i];
    endtask

    task automatic drive_px(int x, int y, logic act);
        logic [23:0] e, got;
        px_x = 10'(x);
        px_y = 10'(y);
        px_active = act;
        px_q.push_back(px_model(x, y, act));
        step(1);
        got = {in_board, tile_word, tile_px, tile_py};
        e = px_q.pop_front();
        vectors++;
        if (got !== e) begin
            errors++;
            $display("FAIL pixel(%0d,%0d,%0d): got in=%0d word=%h px=%0d py=%0d, required in=%0d word=%h px=%0d py=%0d",
                     x, y, act, got[23], got[22:12], got[11:6], got[5:0],
                     e[23], e[22:12], e[11:6], e[5:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        vectors++;
        if ({next_screen, address_read_om, in_board} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got ns=%0d addr=%0d in=%0d, required 0 0 0",
                     next_screen, address_read_om, in_board);
        end
        vectors++;
        if ({tile_word, tile_px, tile_py} !== 23'd0) begin
            errors++;
            $display("FAIL reset_tile: got word=%h px=%0d py=%0d, required 0", tile_word, tile_px, tile_py);
        end
        vectors++;
        if ({star_count, cowboy_pos} !== 21'd0) begin
            errors++;
            $display("FAIL reset_hdr: got star=%0d cow=%h, required 0", star_count, cowboy_pos);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_idle_frame();
        addr_moved = 1'b0;
        pulse_frame(1'b0);
        step(5);
        vectors++;
        if (ns_exp.size() !== 0) begin
            errors++;
            $display("FAIL idle_missing_ns: got %0d pending, required 0", ns_exp.size());
        end
        vectors++;
        if (addr_moved !== 1'b0) begin
            errors++;
            $display("FAIL idle_addr: got address moved, required stay 0");
        end
        drive_px(200, 100, 1'b1);
    endtask

    task automatic test_copy();
        pulse_new_state();
        step(2);
        pulse_frame(1'b1);
        step(110);
        snap_model();
        vectors++;
        if (ns_exp.size() !== 0) begin
            errors++;
            $display("FAIL copy_missing_ns: got %0d pending, required 0", ns_exp.size());
        end
        vectors++;
        if (cowboy_pos !== {7'd4, 7'd7}) begin
            errors++;
            $display("FAIL copy_cowboy: got %h, required %h", cowboy_pos, {7'd4, 7'd7});
        end
        vectors++;
        if (star_count !== 7'd5) begin
            errors++;
            $display("FAIL copy_star: got %0d, required 5", star_count);
        end
    endtask

    task automatic test_pixels();
        int xs[8] = '{234, 79, 80, 559, 560, 300, 300, 0};
        int ys[8] = '{143, 10, 0, 479, 0, 480, 200, 0};
        logic acts[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) drive_px(xs[i], ys[i], acts[i]);
        for (int i = 0; i < 40; i++)
            drive_px(int'($urandom_range(0, 639)), int'($urandom_range(0, 524)), 1'b1);
        // Scan-order run across a tile boundary.
        for (int x = 120; x < 180; x++) drive_px(x, 250, 1'b1);
        px_active = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse_new_state();
        step(2);
        new_state = 1'b1;
        pulse_frame(1'b1);
        new_state = 1'b0;
        step(110);
        mem[100] = 11'd1;
        mem[101] = 11'd2;
        mem[102] = 11'd9;
        mem[55]  = 11'h5a5;
        pulse_frame(1'b1);
        step(110);
        snap_model();
        vectors++;
        if (ns_exp.size() !== 0) begin
            errors++;
            $display("FAIL b2b_missing_ns: got %0d pending, required 0", ns_exp.size());
        end
        vectors++;
        if ({star_count, cowboy_pos} !== {7'd9, 7'd1, 7'd2}) begin
            errors++;
            $display("FAIL b2b_hdr: got star=%0d cow=%h, required star=9 cow=%h",
                     star_count, cowboy_pos, {7'd1, 7'd2});
        end
        drive_px(80 + 5 * 48 + 1, 5 * 48 + 2, 1'b1);
    endtask

    task automatic test_reset_mid_copy();
        pulse_new_state();
        step(2);
        pulse_frame(1'b1);
        step(49);
        rst = 1'b1;
        ns_exp.delete();
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) shadow_m[i] = 11'd0;
        step(120);
        vectors++;
        if ({star_count, cowboy_pos} !== 21'd0) begin
            errors++;
            $display("FAIL rst_copy_hdr: got star=%0d cow=%h, required 0", star_count, cowboy_pos);
        end
        drive_px(80 + 3 * 48, 2 * 48, 1'b1);
        pulse_frame(1'b0);
        step(5);
        vectors++;
        if (ns_exp.size() !== 0) begin
            errors++;
            $display("FAIL rst_copy_ns: got %0d pending, required 0", ns_exp.size());
        end
    endtask

    task automatic test_double_frame();
        pulse_new_state();
        step(2);
        pulse_frame(1'b1);
        step(19);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        step(120);
        snap_model();
        vectors++;
        if (ns_exp.size() !== 0) begin
            errors++;
            $display("FAIL double_missing_ns: got %0d pending, required 0", ns_exp.size());
        end
        vectors++;
        if (star_count !== 7'd9) begin
            errors++;
            $display("FAIL double_star: got %0d, required 9", star_count);
        end
        drive_px(80 + 9 * 48 + 47, 9 * 48 + 47, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        new_state = 1'b0;
        frame_start = 1'b0;
        px_x = '0;
        px_y = '0;
        px_active = 1'b0;
        addr_moved = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 11'((i * 37 + 5) % 2048);
        mem[23]  = {3'd2, 8'd0};
        mem[100] = 11'd4;
        mem[101] = 11'd7;
        mem[102] = 11'd5;
        for (int i = 0; i < 100; i++) shadow_m[i] = 11'd0;

        test_reset();
        test_idle_frame();
        test_copy();
        test_pixels();
        test_back_to_back();
        test_reset_mid_copy();
        test_double_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
